// File: rtl/param_counter.sv
// param_counter: configurable-width, configurable-modulus up/down counter with
// synchronous clear/load, an enable prescaler, a terminal-count pulse and a
// sticky overflow flag.
//
// Build option: define CNT_SATURATE_EN to hold at the boundary (MAX going up,
// 0 going down) instead of wrapping. Wrap-around is the default build.
//
// Legal parameters: 1 <= MAX <= 2**N-1, PRESCALE >= 1.
module param_counter #(
    parameter int unsigned N        = 7,
    parameter int unsigned MAX      = (2 ** N) - 1,
    parameter int unsigned PRESCALE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         dir,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         ovf_clr,
    output logic [N-1:0] cnt,
    output logic         tc,
    output logic         ovf
);

    // Prescaler is at least one bit wide so PRESCALE=1 still elaborates.
    localparam int unsigned PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [N-1:0]  MAX_V   = N'(MAX);
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    logic [N-1:0]  cnt_q, cnt_d;
    logic [PW-1:0] ps_q,  ps_d;
    logic          tc_q,  tc_d;
    logic          ovf_q, ovf_d;

    logic          step_c;
    logic          at_bound_c;
    logic          bnd_c;
    logic [N-1:0]  load_clamped_c;

    // A step happens on the enabled cycle that closes the prescaler period.
    assign step_c         = en && (ps_q == PS_LAST);
    assign at_bound_c     = dir ? (cnt_q == '0) : (cnt_q == MAX_V);
    assign load_clamped_c = (load_val > MAX_V) ? MAX_V : load_val;

    // Next-state: clr > load > step; tc only follows a boundary step.
    always_comb begin
        cnt_d = cnt_q;
        ps_d  = ps_q;
        bnd_c = 1'b0;

        if (clr) begin
            cnt_d = '0;
            ps_d  = '0;
        end else if (load) begin
            cnt_d = load_clamped_c;
            ps_d  = '0;
        end else if (en) begin
            if (step_c) begin
                ps_d = '0;
                if (at_bound_c) begin
                    bnd_c = 1'b1;
`ifdef CNT_SATURATE_EN
                    cnt_d = cnt_q;
`else
                    cnt_d = dir ? MAX_V : '0;
`endif
                end else begin
                    cnt_d = dir ? (cnt_q - N'(1)) : (cnt_q + N'(1));
                end
            end else begin
                ps_d = ps_q + PW'(1);
            end
        end

        tc_d = bnd_c;
        // A boundary event in the same cycle as ovf_clr keeps the flag set.
        if (bnd_c) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ps_q  <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ps_q  <= ps_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = tc_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_param_counter.sv
// Bench for param_counter: three instances (default, N=8/MAX=99, PRESCALE=3)
// share one stimulus stream; a behavioural model pushes expected outputs into
// a scoreboard queue each cycle, popped and compared after the clock edge.
module tb_param_counter;

    logic       clk = 1'b0;
    logic       rst, en, dir, clr, load, ovf_clr;
    logic [7:0] load_val;

    logic [6:0] cnt0, cnt2;
    logic [7:0] cnt1;
    logic       tc0, tc1, tc2, ovf0, ovf1, ovf2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    param_counter u_dut0 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
        .load_val(load_val[6:0]), .ovf_clr(ovf_clr),
        .cnt(cnt0), .tc(tc0), .ovf(ovf0)
    );

    param_counter #(.N(8), .MAX(99), .PRESCALE(1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr),
        .cnt(cnt1), .tc(tc1), .ovf(ovf1)
    );

    param_counter #(.N(7), .MAX(127), .PRESCALE(3)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
        .load_val(load_val[6:0]), .ovf_clr(ovf_clr),
        .cnt(cnt2), .tc(tc2), .ovf(ovf2)
    );

    typedef struct {
        int   inst;
        int   cnt;
        logic tc;
        logic ovf;
    } exp_t;

    exp_t sb_q[$];

    int   m_cnt [3];
    int   m_ps  [3];
    logic m_tc  [3];
    logic m_ovf [3];
    int   max_v [3] = '{127, 99, 127};
    int   pre_v [3] = '{1, 1, 3};
    int   mask_v[3] = '{127, 255, 127};

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    // Reference behaviour for one instance over one clock edge.
    task automatic model_cycle(input int i);
        logic bnd;
        int   lv;
        bnd = 1'b0;
        if (rst) begin
            m_cnt[i] = 0; m_ps[i] = 0; m_tc[i] = 1'b0; m_ovf[i] = 1'b0;
            return;
        end
        if (clr) begin
            m_cnt[i] = 0; m_ps[i] = 0;
        end else if (load) begin
            lv = int'(load_val) & mask_v[i];
            m_cnt[i] = (lv > max_v[i]) ? max_v[i] : lv;
            m_ps[i] = 0;
        end else if (en) begin
            if (m_ps[i] == pre_v[i] - 1) begin
                m_ps[i] = 0;
                if (!dir) begin
                    if (m_cnt[i] == max_v[i]) begin
                        bnd = 1'b1;
`ifndef CNT_SATURATE_EN
                        m_cnt[i] = 0;
`endif
                    end else m_cnt[i] = m_cnt[i] + 1;
                end else begin
                    if (m_cnt[i] == 0) begin
                        bnd = 1'b1;
`ifndef CNT_SATURATE_EN
                        m_cnt[i] = max_v[i];
`endif
                    end else m_cnt[i] = m_cnt[i] - 1;
                end
            end else begin
                m_ps[i] = m_ps[i] + 1;
            end
        end
        m_tc[i] = bnd;
        if (bnd) m_ovf[i] = 1'b1;
        else if (ovf_clr) m_ovf[i] = 1'b0;
    endtask

    // Push expectations, clock once, then drain the scoreboard against the DUTs.
    task automatic tick();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            model_cycle(i);
            e.inst = i; e.cnt = m_cnt[i]; e.tc = m_tc[i]; e.ovf = m_ovf[i];
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.inst)
                0: begin
                    chk("sb_cnt0", int'(cnt0), e.cnt);
                    chk("sb_tc0", int'(tc0), int'(e.tc));
                    chk("sb_ovf0", int'(ovf0), int'(e.ovf));
                end
                1: begin
                    chk("sb_cnt1", int'(cnt1), e.cnt);
                    chk("sb_tc1", int'(tc1), int'(e.tc));
                    chk("sb_ovf1", int'(ovf1), int'(e.ovf));
                end
                default: begin
                    chk("sb_cnt2", int'(cnt2), e.cnt);
                    chk("sb_tc2", int'(tc2), int'(e.tc));
                    chk("sb_ovf2", int'(ovf2), int'(e.ovf));
                end
            endcase
        end
    endtask

    task automatic idle();
        rst = 1'b0; en = 1'b0; dir = 1'b0; clr = 1'b0; load = 1'b0;
        ovf_clr = 1'b0; load_val = 8'd0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_ps[i] = 0; m_tc[i] = 1'b0; m_ovf[i] = 1'b0;
        end
        idle();
        rst = 1'b1;
        tick();
        chk("reset_cnt0", int'(cnt0), 0);
        chk("reset_tc0", int'(tc0), 0);
        chk("reset_ovf0", int'(ovf0), 0);
        rst = 1'b0;

        // Random prior state, then a single reset cycle.
        for (int k = 0; k < 40; k++) begin
            en = 1'b1; dir = 1'($urandom_range(0, 1));
            load = ($urandom_range(0, 7) == 0); load_val = 8'($urandom_range(0, 255));
            tick();
        end
        idle();
        rst = 1'b1;
        tick();
        chk("rst_rand_cnt1", int'(cnt1), 0);
        chk("rst_rand_ovf1", int'(ovf1), 0);
        chk("rst_rand_cnt2", int'(cnt2), 0);
        rst = 1'b0;

        // Wrap up at 127 on the default instance.
        load = 1'b1; load_val = 8'd126;
        tick();
        load = 1'b0;
        chk("wrap_load", int'(cnt0), 126);
        en = 1'b1;
        tick();
        chk("wrap_cnt127", int'(cnt0), 127);
        chk("wrap_tc_pre", int'(tc0), 0);
        tick();
`ifdef CNT_SATURATE_EN
        chk("sat_cnt2nd", int'(cnt0), 127);
        chk("sat_tc2nd", int'(tc0), 1);
        tick();
        chk("sat_cnt3rd", int'(cnt0), 127);
        chk("sat_tc3rd", int'(tc0), 1);
        rst = 1'b1;
        tick();
        chk("sat_rst_cnt", int'(cnt0), 0);
        chk("sat_rst_ovf", int'(ovf0), 0);
        rst = 1'b0;
        load = 1'b1; load_val = 8'd127; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
`else
        chk("wrap_cnt0", int'(cnt0), 0);
`endif
        chk("wrap_tc", int'(tc0), 1);
        chk("wrap_ovf", int'(ovf0), 1);
        en = 1'b0;
        tick();
        chk("wrap_tc_drop", int'(tc0), 0);
        chk("wrap_ovf_sticky", int'(ovf0), 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr_alone", int'(ovf0), 0);

        // Modulus 99: load clamps, then a down step from 0 wraps to MAX.
        load = 1'b1; load_val = 8'd200;
        tick();
        load = 1'b0;
        chk("mod_clamp", int'(cnt1), 99);
        clr = 1'b1;
        tick();
        clr = 1'b0; dir = 1'b1; en = 1'b1;
        tick();
`ifdef CNT_SATURATE_EN
        chk("mod_down_sat", int'(cnt1), 0);
`else
        chk("mod_down_wrap", int'(cnt1), 99);
`endif
        chk("mod_down_tc", int'(tc1), 1);
        idle();

        // Prescale 3: seven enabled cycles with an en=0 gap keep their phase.
        clr = 1'b1;
        tick();
        clr = 1'b0; en = 1'b1;
        tick(); tick();
        chk("pre_hold2", int'(cnt2), 0);
        en = 1'b0;
        tick(); tick();
        chk("pre_gap", int'(cnt2), 0);
        en = 1'b1;
        tick();
        chk("pre_step1", int'(cnt2), 1);
        tick(); tick();
        chk("pre_hold5", int'(cnt2), 1);
        tick();
        chk("pre_step2", int'(cnt2), 2);
        tick();
        chk("pre_final", int'(cnt2), 2);
        idle();

        // Priority: clr over load over step.
        load = 1'b1; load_val = 8'd40;
        tick();
        clr = 1'b1; load = 1'b1; load_val = 8'd50; en = 1'b1;
        tick();
        chk("prio_cnt0", int'(cnt0), 0);
        chk("prio_cnt1", int'(cnt1), 0);
        idle();

        // Boundary with ovf_clr in the same cycle: set wins.
        load = 1'b1; load_val = 8'd127;
        tick();
        load = 1'b0; en = 1'b1; ovf_clr = 1'b1;
        tick();
        chk("set_wins_ovf", int'(ovf0), 1);
        chk("set_wins_tc", int'(tc0), 1);
        en = 1'b0;
        tick();
        chk("ovf_clr_after", int'(ovf0), 0);
        idle();

        // Random soak, scoreboard only.
        for (int k = 0; k < 400; k++) begin
            rst      = ($urandom_range(0, 63) == 0);
            clr      = ($urandom_range(0, 31) == 0);
            load     = ($urandom_range(0, 15) == 0);
            load_val = 8'($urandom_range(0, 255));
            en       = ($urandom_range(0, 3) != 0);
            dir      = 1'($urandom_range(0, 1));
            ovf_clr  = ($urandom_range(0, 15) == 0);
            tick();
        end
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
